// File: rtl/anubis_pkg.sv
// Shared types and constants for the Anubis round controller and its round counter.
package anubis_pkg;

  localparam int unsigned NMIN   = 4;
  localparam int unsigned NMAX   = 10;
  localparam int unsigned RBASE  = 8;
  localparam int unsigned KIDX_W = 5;

  typedef enum logic [2:0] {
    StIdle,
    StKwait,
    StRound,
    StFinal,
    StHold
  } state_e;

  function automatic logic keylen_legal(input logic [3:0] n);
    return (n >= 4'(NMIN)) && (n <= 4'(NMAX));
  endfunction

endpackage

// File: rtl/anubis_round_counter.sv
// Round counter r, round count R = 8 + N, latched mode and the round-key index mapping.
module anubis_round_counter
  import anubis_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic              i_decrypt,
  input  logic [3:0]        i_keylen,
  input  logic              i_inc,
  input  logic              i_clear,
  output logic [KIDX_W-1:0] o_key_idx,
  output logic              o_pre_final,
  output logic              o_at_final,
  output logic              o_mode
);

  logic [KIDX_W-1:0] r_round;
  logic [KIDX_W-1:0] r_nrounds;
  logic              r_mode;
  logic [KIDX_W-1:0] w_nrounds_in;

  assign w_nrounds_in = KIDX_W'(RBASE) + {1'b0, i_keylen};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_round   <= '0;
      r_nrounds <= '0;
      r_mode    <= 1'b0;
    end else if (i_clear) begin
      r_round   <= '0;
      r_nrounds <= '0;
      r_mode    <= 1'b0;
    end else if (i_load) begin
      r_round   <= KIDX_W'(1);
      r_nrounds <= w_nrounds_in;
      r_mode    <= i_decrypt;
    end else if (i_inc && (r_round < r_nrounds)) begin
      // Saturates at R so the counter can never wrap.
      r_round <= r_round + KIDX_W'(1);
    end
  end

  // During the accept cycle the index is derived from the request itself.
  always_comb begin
    o_key_idx = r_round;
    if (i_load) begin
      o_key_idx = i_decrypt ? w_nrounds_in : '0;
    end else if (r_mode) begin
      o_key_idx = r_nrounds - r_round;
    end
  end

  assign o_pre_final = (r_round == (r_nrounds - KIDX_W'(1)));
  assign o_at_final  = (r_round == r_nrounds) && (r_nrounds != '0);
  assign o_mode      = r_mode;

endmodule

// File: rtl/anubis_round_controller.sv
// Anubis round sequencer: request handshake, key-wait stalls and result hold.
module anubis_round_controller
  import anubis_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_decrypt,
  input  logic [3:0]        in_keylen,
  input  logic              key_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              ctl_load,
  output logic              ctl_round_en,
  output logic              ctl_last_round,
  output logic [KIDX_W-1:0] ctl_key_idx,
  output logic              ctl_decrypt,
  output logic              busy,
  output logic              err_keylen
);

  state_e            r_state;
  state_e            w_state_next;
  logic              r_live;
  logic              w_accept;
  logic              w_load;
  logic              w_inc;
  logic              w_clear;
  logic [KIDX_W-1:0] w_key_idx;
  logic              w_pre_final;
  logic              w_at_final;
  logic              w_mode;

  // r_live keeps in_ready low until the first clock after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_live  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_live  <= 1'b1;
    end
  end

  assign in_ready = (r_state == StIdle) && r_live;
  assign w_accept = in_valid && in_ready;
  assign busy     = (r_state != StIdle);

  always_comb begin
    w_state_next   = r_state;
    w_load         = 1'b0;
    w_inc          = 1'b0;
    w_clear        = 1'b0;
    out_valid      = 1'b0;
    ctl_load       = 1'b0;
    ctl_round_en   = 1'b0;
    ctl_last_round = 1'b0;
    ctl_key_idx    = '0;
    ctl_decrypt    = 1'b0;
    err_keylen     = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          if (keylen_legal(in_keylen)) begin
            w_load       = 1'b1;
            ctl_load     = 1'b1;
            ctl_key_idx  = w_key_idx;
            ctl_decrypt  = in_decrypt;
            w_state_next = StRound;
          end else begin
            err_keylen = 1'b1;
          end
        end
      end
      StRound: begin
        ctl_key_idx = w_key_idx;
        ctl_decrypt = w_mode;
        if (key_ready) begin
          ctl_round_en = 1'b1;
          w_inc        = 1'b1;
          w_state_next = w_pre_final ? StFinal : StRound;
        end else begin
          w_state_next = StKwait;
        end
      end
      StFinal: begin
        ctl_key_idx = w_key_idx;
        ctl_decrypt = w_mode;
        if (key_ready) begin
          ctl_round_en   = 1'b1;
          ctl_last_round = 1'b1;
          w_state_next   = StHold;
        end else begin
          w_state_next = StKwait;
        end
      end
      StKwait: begin
        ctl_key_idx = w_key_idx;
        ctl_decrypt = w_mode;
        // r only reaches R in FINAL, so it identifies the state to resume.
        if (key_ready) begin
          w_state_next = w_at_final ? StFinal : StRound;
        end
      end
      StHold: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_clear      = 1'b1;
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  anubis_round_counter u_round_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_load),
    .i_decrypt  (in_decrypt),
    .i_keylen   (in_keylen),
    .i_inc      (w_inc),
    .i_clear    (w_clear),
    .o_key_idx  (w_key_idx),
    .o_pre_final(w_pre_final),
    .o_at_final (w_at_final),
    .o_mode     (w_mode)
  );

endmodule
